// File: rtl/sdp_x_mul_op_sched.sv
// Sequences one layer of X-path multiplier operands: register constant or streamed word reused N beats.
// Latency: constant valid 1 cycle after op_start, stream valid 1 cycle after the accepted load.
// Backpressure: FETCH holds lz until vz arrives; HOLD keeps core_op stable until core_op_rdy.
module sdp_x_mul_op_sched #(
    parameter int DW      = 256,
    parameter int REUSE_W = 13,
    parameter int BEAT_W  = 32
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic               op_start,
    input  logic               cfg_mul_src,
    input  logic [15:0]        cfg_mul_const,
    input  logic [REUSE_W-1:0] cfg_mul_reuse,
    input  logic [BEAT_W-1:0]  cfg_beats,
    input  logic [DW-1:0]      chn_mul_op_rsc_z,
    input  logic               chn_mul_op_rsc_vz,
    output logic               chn_mul_op_rsc_lz,
    output logic               core_op_vld,
    output logic [DW-1:0]      core_op,
    input  logic               core_op_rdy,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [REUSE_W-1:0] REUSE_ONE = REUSE_W'(1);
    localparam logic [BEAT_W-1:0]  BEAT_ONE  = BEAT_W'(1);

    state_t               state;
    logic                 src_q;
    logic [REUSE_W-1:0]   reuse_q;
    logic [REUSE_W-1:0]   reuse_cnt;
    logic [BEAT_W-1:0]    beats_q;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [DW-1:0]        op_q;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state     <= IDLE;
            src_q     <= 1'b0;
            reuse_q   <= '0;
            reuse_cnt <= '0;
            beats_q   <= '0;
            beat_cnt  <= '0;
            op_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_start) begin
                        src_q     <= cfg_mul_src;
                        reuse_q   <= cfg_mul_reuse;
                        beats_q   <= cfg_beats;
                        reuse_cnt <= '0;
                        beat_cnt  <= '0;
                        if (cfg_mul_src) begin
                            state <= FETCH;
                        end else begin
                            op_q  <= {(DW/16){cfg_mul_const}};
                            state <= HOLD;
                        end
                    end
                end
                FETCH: begin
                    if (chn_mul_op_rsc_vz) begin
                        op_q  <= chn_mul_op_rsc_z;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (core_op_rdy) begin
                        // Layer end wins over a reuse wrap so the last beat never triggers a fetch.
                        if (beat_cnt == beats_q) begin
                            state <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_ONE;
                            if (reuse_cnt == reuse_q) begin
                                reuse_cnt <= '0;
                                if (src_q) begin
                                    state <= FETCH;
                                end
                            end else begin
                                reuse_cnt <= reuse_cnt + REUSE_ONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign chn_mul_op_rsc_lz = (state == FETCH);
    assign core_op_vld       = (state == HOLD);
    assign busy              = (state != IDLE);
    assign done              = (state == DONE);
    assign core_op           = op_q;

endmodule

// File: tb/tb_sdp_x_mul_op_sched.sv
// Bench for sdp_x_mul_op_sched: table of layers checked through an operand scoreboard plus reset corner cases.
module tb_sdp_x_mul_op_sched;

    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_start = 1'b0;
    logic          cfg_mul_src = 1'b0;
    logic [15:0]   cfg_mul_const = '0;
    logic [12:0]   cfg_mul_reuse = '0;
    logic [31:0]   cfg_beats = '0;
    logic [DW-1:0] z = '0;
    logic          vz = 1'b0;
    logic          lz;
    logic          core_op_vld;
    logic [DW-1:0] core_op;
    logic          core_op_rdy = 1'b1;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    sdp_x_mul_op_sched dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rst    (rst),
        .op_start          (op_start),
        .cfg_mul_src       (cfg_mul_src),
        .cfg_mul_const     (cfg_mul_const),
        .cfg_mul_reuse     (cfg_mul_reuse),
        .cfg_beats         (cfg_beats),
        .chn_mul_op_rsc_z  (z),
        .chn_mul_op_rsc_vz (vz),
        .chn_mul_op_rsc_lz (lz),
        .core_op_vld       (core_op_vld),
        .core_op           (core_op),
        .core_op_rdy       (core_op_rdy),
        .busy              (busy),
        .done              (done)
    );

    typedef struct {
        logic        src;
        logic [15:0] cst;
        logic [12:0] reuse;
        logic [31:0] beats;
        int          stall;
        logic        rdy_tog;
        logic        poke;
        int          exp_beats;
        int          exp_xfers;
        int          exp_lz;
        int          exp_done_off;
    } vec_t;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    logic [7:0]    layer_id = 8'd0;
    int            stall_left = 0;
    logic          rdy_tog = 1'b0;
    logic          vz_en = 1'b1;
    int            xfer_cnt = 0;
    int            lz_cnt = 0;
    int            beat_seen = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    logic          hold_stall = 1'b0;
    logic [DW-1:0] prev_op = '0;
    logic [DW-1:0] exp_q[$];

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [DW-1:0] word_fn(logic [7:0] id, int idx);
        logic [31:0] idx32;
        logic [31:0] w;
        idx32 = idx;
        w = {id, 8'h5A, idx32[15:0]};
        return {(DW/32){w}};
    endfunction

    always @(posedge clk) cyc++;

    // Source and sink models: stream word follows the transfer count, optional stall and rdy toggling.
    always @(posedge clk) begin
        #1;
        z = word_fn(layer_id, xfer_cnt);
        if (lz && stall_left > 0) begin
            vz = 1'b0;
            stall_left--;
        end else begin
            vz = vz_en;
        end
        core_op_rdy = rdy_tog ? ~core_op_rdy : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (core_op_vld && core_op_rdy) begin
                beat_seen++;
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("beat_op", core_op, exp_q.pop_front());
            end
            if (lz && vz) xfer_cnt++;
            if (lz) lz_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hold_stall && core_op_vld) check("op_stable", core_op, prev_op);
            hold_stall = core_op_vld && !core_op_rdy;
            prev_op    = core_op;
        end else begin
            hold_stall = 1'b0;
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_lz"},   lz, 0);
        check({tag, "_vld"},  core_op_vld, 0);
        check({tag, "_op"},   core_op, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic run_layer(input vec_t v);
        int   n;
        int   t0;
        logic got;
        layer_id++;
        xfer_cnt   = 0;
        lz_cnt     = 0;
        beat_seen  = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        stall_left = v.stall;
        rdy_tog    = v.rdy_tog;
        exp_q.delete();
        for (int i = 0; i <= int'(v.beats); i++) begin
            if (v.src) exp_q.push_back(word_fn(layer_id, i / (int'(v.reuse) + 1)));
            else       exp_q.push_back({(DW/16){v.cst}});
        end
        cfg_mul_src   = v.src;
        cfg_mul_const = v.cst;
        cfg_mul_reuse = v.reuse;
        cfg_beats     = v.beats;
        op_start      = 1'b1;
        t0  = cyc + 1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 500) begin
            @(posedge clk); #1;
            n++;
            if (done) got = 1'b1;
            // Starts with conflicting cfg while busy must be dropped.
            if (v.poke && busy) begin
                op_start      = 1'b1;
                cfg_mul_src   = ~v.src;
                cfg_mul_const = 16'hBEEF;
                cfg_mul_reuse = '0;
                cfg_beats     = '0;
            end else begin
                op_start = 1'b0;
            end
        end
        check("done_seen", got, 1);
        @(posedge clk); #1;
        op_start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        @(posedge clk); #1;
        check("stay_idle", busy, 0);
        check("beats", beat_seen, v.exp_beats);
        check("xfers", xfer_cnt, v.exp_xfers);
        check("lz_cycles", lz_cnt, v.exp_lz);
        check("done_pulses", done_cnt, 1);
        check("sb_drained", exp_q.size(), 0);
        if (v.exp_done_off >= 0) check("done_latency", done_cyc - t0, v.exp_done_off);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{src:1'b0, cst:16'h3C00, reuse:13'd0, beats:32'd7, stall:0, rdy_tog:1'b0, poke:1'b0,
                    exp_beats:8, exp_xfers:0, exp_lz:0, exp_done_off:8};
        vecs[1] = '{src:1'b1, cst:16'h0000, reuse:13'd2, beats:32'd8, stall:0, rdy_tog:1'b0, poke:1'b0,
                    exp_beats:9, exp_xfers:3, exp_lz:3, exp_done_off:12};
        vecs[2] = '{src:1'b1, cst:16'h0000, reuse:13'd0, beats:32'd3, stall:4, rdy_tog:1'b1, poke:1'b0,
                    exp_beats:4, exp_xfers:4, exp_lz:8, exp_done_off:-1};
        vecs[3] = '{src:1'b1, cst:16'h0000, reuse:13'd5, beats:32'd0, stall:0, rdy_tog:1'b0, poke:1'b0,
                    exp_beats:1, exp_xfers:1, exp_lz:1, exp_done_off:2};
        vecs[4] = '{src:1'b1, cst:16'h0000, reuse:13'd1, beats:32'd3, stall:0, rdy_tog:1'b0, poke:1'b1,
                    exp_beats:4, exp_xfers:2, exp_lz:2, exp_done_off:6};
        vecs[5] = '{src:1'b0, cst:16'h1234, reuse:13'd3, beats:32'd4, stall:0, rdy_tog:1'b1, poke:1'b0,
                    exp_beats:5, exp_xfers:0, exp_lz:0, exp_done_off:-1};
        vecs[6] = '{src:1'b1, cst:16'h0000, reuse:13'd0, beats:32'd2, stall:0, rdy_tog:1'b0, poke:1'b0,
                    exp_beats:3, exp_xfers:3, exp_lz:3, exp_done_off:6};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) run_layer(vecs[k]);

        // Reset while FETCH is offered a valid word: the word must not be captured.
        rdy_tog    = 1'b0;
        stall_left = 0;
        vz_en      = 1'b1;
        cfg_mul_src   = 1'b1;
        cfg_mul_reuse = 13'd1;
        cfg_beats     = 32'd5;
        op_start      = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        check("pre_rst_fetch_lz", lz, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_fetch");
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset while HOLD is being accepted.
        cfg_mul_src   = 1'b0;
        cfg_mul_const = 16'h7777;
        cfg_beats     = 32'd20;
        op_start      = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        check("pre_rst_hold_vld", core_op_vld, 1);
        check("pre_rst_hold_op", core_op, {(DW/16){16'h7777}});
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_hold");
        rst = 1'b0;
        @(posedge clk); #1;

        run_layer(vecs[1]);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
